fnd_count_scan_ctrl: RTL and testbench

- Source side of the FND display path. A two-digit BCD stopwatch counter (00-99) with a run/pause/idle state machine.
- Outputs the two digit values, the digit-select (mode) and blank (onOff) controls consumed by the 2:1 digit mux, and the active-low FND common lines.
- Generates its own scan, count and blink ticks from the system clock.

---
 rtl/fnd_pkg.sv | 30 +++
 rtl/fnd_count_scan_ctrl_if.sv | 23 ++
 rtl/clk_div_tick.sv | 30 +++
 rtl/fnd_count_scan_ctrl.sv | 90 +++++++++
 tb/tb_fnd_count_scan_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND stopwatch source path.
// No timing of its own: enums, common-line codes and a BCD increment helper.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] FND_COM_D0 = 4'b1110;
  localparam logic [3:0] FND_COM_D1 = 4'b1101;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // Packed {tens, ones}; 99 rolls over to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones < BCD_MAX) begin
      ones = ones + 4'd1;
    end else begin
      ones = 4'd0;
      tens = (tens < BCD_MAX) ? tens + 4'd1 : 4'd0;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/fnd_count_scan_ctrl_if.sv
// Button/level inputs and display-side outputs of the stopwatch source block.
// Slave is the controller; master is whoever drives the buttons and reads the display.
interface fnd_count_scan_ctrl_if;
  logic       i_btnRunStop;
  logic       i_btnClear;
  logic       i_dispOff;
  logic [3:0] o_digit_a;
  logic [3:0] o_digit_b;
  logic       o_mode;
  logic       o_onOff;
  logic [3:0] o_fndCom;
  logic [1:0] o_state;

  modport master (
    output i_btnRunStop, i_btnClear, i_dispOff,
    input  o_digit_a, o_digit_b, o_mode, o_onOff, o_fndCom, o_state
  );

  modport slave (
    input  i_btnRunStop, i_btnClear, i_dispOff,
    output o_digit_a, o_digit_b, o_mode, o_onOff, o_fndCom, o_state
  );
endinterface

// File: rtl/clk_div_tick.sv
// Modulo-DIV prescaler emitting a one-cycle tick in its terminal-count cycle.
// Clear beats enable; while disabled the count holds and no tick is produced.
module clk_div_tick #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign o_tick = i_en & ~i_clr & (cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/fnd_count_scan_ctrl.sv
// Two-digit BCD stopwatch with idle/run/pause control, digit scan and pause blink.
// All outputs come from registers; i_dispOff reaches o_onOff one cycle later.
module fnd_count_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int COUNT_DIV = 10_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fnd_count_scan_ctrl_if.slave  bus
);

  state_t     state;
  state_t     state_nxt;
  logic       scan_tick;
  logic       count_tick;
  logic       blink_tick;
  logic [7:0] digits;
  logic       mode;
  logic       blink_phase;
  logic       dispoff_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.i_btnRunStop) state_nxt = ST_RUN;
      ST_RUN:   if (bus.i_btnRunStop) state_nxt = ST_PAUSE;
      ST_PAUSE: if (bus.i_btnRunStop) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    if (bus.i_btnClear) state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  clk_div_tick #(.DIV(SCAN_DIV)) u_scan_div (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (1'b1),
    .i_clr  (1'b0),
    .o_tick (scan_tick)
  );

  // Pause leaves the count prescaler untouched so resume finishes the partial period.
  clk_div_tick #(.DIV(COUNT_DIV)) u_count_div (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (state == ST_RUN),
    .i_clr  (bus.i_btnClear | (state == ST_IDLE)),
    .o_tick (count_tick)
  );

  clk_div_tick #(.DIV(BLINK_DIV)) u_blink_div (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (state == ST_PAUSE),
    .i_clr  (bus.i_btnClear | (state != ST_PAUSE)),
    .o_tick (blink_tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      digits      <= 8'h00;
      mode        <= 1'b0;
      blink_phase <= 1'b0;
      dispoff_q   <= 1'b0;
    end else begin
      mode      <= mode ^ scan_tick;
      dispoff_q <= bus.i_dispOff;
      if (bus.i_btnClear)  digits <= 8'h00;
      else if (count_tick) digits <= bcd_inc(digits);
      // Phase starts visible on every entry into pause.
      if ((state == ST_PAUSE) && (state_nxt == ST_PAUSE)) blink_phase <= blink_phase ^ blink_tick;
      else                                                 blink_phase <= 1'b0;
    end
  end

  assign bus.o_digit_a = digits[3:0];
  assign bus.o_digit_b = digits[7:4];
  assign bus.o_mode    = mode;
  assign bus.o_fndCom  = mode ? FND_COM_D1 : FND_COM_D0;
  assign bus.o_onOff   = dispoff_q | ((state == ST_PAUSE) & blink_phase);
  assign bus.o_state   = state;

endmodule

// File: tb/tb_fnd_count_scan_ctrl.sv
// Bench for fnd_count_scan_ctrl: directed scenarios plus random button traffic,
// compared each cycle with a cycle-count based reference of the stopwatch.
module tb_fnd_count_scan_ctrl;

  localparam int SCAN  = 4;
  localparam int COUNT = 3;
  localparam int BLINK = 5;

  logic clk;
  logic rst;
  fnd_count_scan_ctrl_if bus();

  fnd_count_scan_ctrl #(
    .SCAN_DIV (SCAN),
    .COUNT_DIV(COUNT),
    .BLINK_DIV(BLINK)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference: elapsed cycles since reset, cycles spent running since clear,
  // cycles spent in the current pause, and the state as 0/1/2.
  int cyc;
  int run_cyc;
  int pause_cyc;
  int st;
  bit doff_m;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; run_cyc = 0; pause_cyc = 0; st = 0; doff_m = 1'b0;
  endtask

  task automatic model_edge(input bit rs, input bit clr, input bit doff);
    cyc++;
    doff_m = doff;
    if (clr) begin
      st = 0; run_cyc = 0; pause_cyc = 0;
    end else begin
      if (st == 1) run_cyc++;
      else if (st == 2) pause_cyc++;
      if (rs) begin
        if (st == 0)      st = 1;
        else if (st == 1) begin st = 2; pause_cyc = 0; end
        else              st = 1;
      end
    end
  endtask

  task automatic check_all();
    int val;
    bit exp_mode;
    bit exp_off;
    val      = (run_cyc / COUNT) % 100;
    exp_mode = ((cyc / SCAN) % 2) == 1;
    exp_off  = doff_m | ((st == 2) && (((pause_cyc / BLINK) % 2) == 1));
    chk("digit_a", 8'(bus.o_digit_a), 8'(val % 10));
    chk("digit_b", 8'(bus.o_digit_b), 8'(val / 10));
    chk("mode",    8'(bus.o_mode),    8'(exp_mode));
    chk("fndcom",  8'(bus.o_fndCom),  exp_mode ? 8'h0D : 8'h0E);
    chk("onoff",   8'(bus.o_onOff),   8'(exp_off));
    chk("state",   8'(bus.o_state),   8'(st));
  endtask

  task automatic step_in(input bit rs, input bit clr, input bit doff);
    bus.i_btnRunStop = rs;
    bus.i_btnClear   = clr;
    bus.i_dispOff    = doff;
    @(posedge clk);
    model_edge(rs, clr, doff);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_a"},     8'(bus.o_digit_a), 8'h00);
    chk({tag, "_b"},     8'(bus.o_digit_b), 8'h00);
    chk({tag, "_mode"},  8'(bus.o_mode),    8'h00);
    chk({tag, "_onoff"}, 8'(bus.o_onOff),   8'h00);
    chk({tag, "_com"},   8'(bus.o_fndCom),  8'h0E);
    chk({tag, "_state"}, 8'(bus.o_state),   8'h00);
  endtask

  initial begin
    bit doff_lvl;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_btnRunStop = 1'b0;
    bus.i_btnClear   = 1'b0;
    bus.i_dispOff    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;

    // Scan runs in idle with no buttons.
    repeat (12) step_in(0, 0, 0);

    // Start and count through 09->10, 99->00.
    step_in(1, 0, 0);
    repeat (310) step_in(0, 0, 0);

    // Pause one clock after a tick, watch the blink, then resume.
    for (int i = 0; i < 10 && (run_cyc % COUNT) != 0; i++) step_in(0, 0, 0);
    step_in(1, 0, 0);
    repeat (23) step_in(0, 0, 0);
    step_in(1, 0, 0);
    repeat (6) step_in(0, 0, 0);

    // Clear and run/stop together at 42.
    for (int i = 0; i < 400 && !(bus.o_digit_b == 4'd4 && bus.o_digit_a == 4'd2); i++)
      step_in(0, 0, 0);
    chk("reach42", {bus.o_digit_b, bus.o_digit_a}, 8'h42);
    step_in(1, 1, 0);
    repeat (8) step_in(0, 0, 0);

    // Display-off pulse while running.
    step_in(1, 0, 0);
    repeat (4) step_in(0, 0, 0);
    repeat (3) step_in(0, 0, 1);
    repeat (6) step_in(0, 0, 0);

    // Random button traffic.
    doff_lvl = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) doff_lvl = ~doff_lvl;
      step_in($urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0, doff_lvl);
    end

    // Asynchronous reset in the middle of a run at 37.
    step_in(0, 1, 0);
    step_in(1, 0, 0);
    for (int i = 0; i < 400 && !(bus.o_digit_b == 4'd3 && bus.o_digit_a == 4'd7); i++)
      step_in(0, 0, 0);
    chk("reach37", {bus.o_digit_b, bus.o_digit_a}, 8'h37);
    #2 rst = 1'b1;
    #1 check_reset_vals("arst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) step_in(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
